mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024, byte address mapped to data-memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 65536, number of 32-bit words in the data memory.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 1..15, cycles the memory strobe phase lasts.
REQ-004 SHALL have ports, clock and reset first:
  clk  input  1  single clock, all state updates on rising edge
  rst  input  1  reset, asynchronous, active-high
  req_valid  input  1  pipeline MEM-stage access request
  req_read  input  1  1 = load, 0 = store
  req_addr  input  32  byte address
  req_wdata  input  32  signed store data
  req_ready  output  1  controller can accept a request
  MEMread  output  1  read strobe to data memory
  MEMwrite  output  1  write strobe to data memory
  address  output  32  byte address to data memory
  data  output  32  signed write data to data memory
  MEM_result  input  32  signed combinational read data from memory
  resp_valid  output  1  one-cycle completion pulse
  resp_rdata  output  32  signed load result
  resp_err  output  1  completed access was rejected
  freeze  output  1  stall request to pipeline

Function
REQ-005 SHALL implement states IDLE, ACCESS, DONE.
REQ-006 SHALL drive req_ready=1 only in IDLE; freeze=1 in ACCESS and DONE, and 0 in IDLE.
REQ-007 SHALL accept a request on a rising edge in IDLE with req_valid=1, latching req_read, req_addr, req_wdata.
REQ-008 SHALL classify an accepted address as invalid if req_addr<BASE_ADDR, req_addr>=BASE_ADDR+4*MEM_WORDS (33-bit compare, no wrap-around), or req_addr[1:0]!=0.
REQ-009 SHALL, on an invalid address, go IDLE->DONE directly, with resp_err=1 and no MEMread/MEMwrite asserted.
REQ-010 SHALL, on a valid address, go IDLE->ACCESS and load a wait counter with WAIT_CYCLES.
REQ-011 SHALL, for a load in ACCESS, hold MEMread=1 for all WAIT_CYCLES cycles and capture MEM_result into resp_rdata on the edge leaving ACCESS.
REQ-012 SHALL, for a store in ACCESS, assert MEMwrite=1 only in the first ACCESS cycle (exactly one write edge), then idle-wait for the remaining cycles.
REQ-013 SHALL decrement the counter each ACCESS cycle and move ACCESS->DONE on the edge where the counter equals 1.
REQ-014 SHALL hold address and data equal to the latched values throughout ACCESS; they retain their last values in IDLE and DONE.
REQ-015 SHALL never assert MEMread and MEMwrite together; both SHALL be 0 outside ACCESS.
REQ-016 SHALL assert resp_valid for exactly the one DONE cycle and then return unconditionally to IDLE.
REQ-017 SHALL drive resp_err=1 in DONE only for rejected requests; otherwise 0.
REQ-018 SHALL leave resp_rdata unchanged on store and rejected completions.
REQ-019 SHALL give valid-access latency: acceptance edge E, resp_valid high in cycle E+WAIT_CYCLES+1; rejected: resp_valid in cycle E+1.
REQ-020 SHALL ignore req_valid outside IDLE; a request held across DONE SHALL be accepted on the first IDLE edge, giving back-to-back throughput of one access per WAIT_CYCLES+2 cycles.

Reset
REQ-021 SHALL, on rst=1, immediately (without waiting for clk) force IDLE, MEMread=0, MEMwrite=0, resp_valid=0, resp_err=0, freeze=0, and address, data, resp_rdata and the counter to 0; req_ready=1.
REQ-022 SHALL abandon any in-flight access on reset mid-operation, with no response pulse after reset release.

Verification
REQ-023 Store, WAIT_CYCLES=1: addr=1032, wdata=-5 -> MEMwrite high 1 cycle with address=1032, data=-5; resp_valid 2 cycles after acceptance, resp_err=0.
REQ-024 Load, WAIT_CYCLES=3, memory returning 77 for addr 1032 -> MEMread high 3 cycles; resp_valid at E+4; resp_rdata=77.
REQ-025 Invalid addrs 1020, 1026, 263168 -> no strobes; resp_valid at E+1 with resp_err=1; resp_rdata unchanged.
REQ-026 Back-to-back: req_valid held high for store then load -> second accepted on the first IDLE edge; freeze high during ACCESS and DONE only.
REQ-027 rst asserted mid-ACCESS of a load -> MEMread drops asynchronously, no resp_valid afterwards, and all outputs at reset values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage data-memory access controller with address checking and a fixed-length strobe phase.
// Latency: valid access -> resp_valid WAIT_CYCLES+1 cycles after acceptance; rejected access -> 1 cycle.
// Backpressure: req_ready only in IDLE, freeze stalls the pipeline while an access is in flight.
module mem_access_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned MEM_WORDS   = 65536,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        MEMread,
    output logic        MEMwrite,
    output logic [31:0] address,
    output logic [31:0] data,
    input  logic [31:0] MEM_result,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        freeze
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Window bounds kept at 33 bits so BASE_ADDR + 4*MEM_WORDS cannot wrap.
    localparam logic [63:0] ADDR_HI_64 = 64'(BASE_ADDR) + 64'(MEM_WORDS) * 64'd4;
    localparam logic [32:0] ADDR_LO    = 33'(BASE_ADDR);
    localparam logic [32:0] ADDR_HI    = ADDR_HI_64[32:0];
    localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        lat_read;
    logic        lat_err;
    logic        addr_ok;

    // Address is usable only inside the mapped window and word aligned.
    always_comb begin
        addr_ok = ({1'b0, req_addr} >= ADDR_LO) &&
                  ({1'b0, req_addr} <  ADDR_HI) &&
                  (req_addr[1:0] == 2'b00);
    end

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe/handshake decode; outputs depend on state only so reset clears them at once.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        freeze     = 1'b0;
        MEMread    = 1'b0;
        MEMwrite   = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = addr_ok ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                freeze   = 1'b1;
                MEMread  = lat_read;
                // Stores write on the first strobe cycle only, then just wait out the phase.
                MEMwrite = !lat_read && (cnt == CNT_INIT);
                if (cnt == 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                freeze     = 1'b1;
                resp_valid = 1'b1;
                resp_err   = lat_err;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, wait counter and load-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            lat_read   <= 1'b0;
            lat_err    <= 1'b0;
            address    <= 32'd0;
            data       <= 32'd0;
            resp_rdata <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_read <= req_read;
                lat_err  <= !addr_ok;
                cnt      <= CNT_INIT;
                // Rejected requests never reach the memory, so its bus keeps its previous value.
                if (addr_ok) begin
                    address <= req_addr;
                    data    <= req_wdata;
                end
            end
            if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
                if (lat_read && cnt == 4'd1) begin
                    resp_rdata <= MEM_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;

    // WAIT_CYCLES = 1 instance
    logic        req_valid1, req_read1;
    logic [31:0] req_addr1, req_wdata1;
    logic        req_ready1, MEMread1, MEMwrite1;
    logic [31:0] address1, data1, MEM_result1, resp_rdata1;
    logic        resp_valid1, resp_err1, freeze1;

    // WAIT_CYCLES = 3 instance
    logic        req_valid3, req_read3;
    logic [31:0] req_addr3, req_wdata3;
    logic        req_ready3, MEMread3, MEMwrite3;
    logic [31:0] address3, data3, MEM_result3, resp_rdata3;
    logic        resp_valid3, resp_err3, freeze3;

    int checks;
    int errors;

    mem_access_ctrl #(.BASE_ADDR(1024), .MEM_WORDS(65536), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_read(req_read1), .req_addr(req_addr1), .req_wdata(req_wdata1),
        .req_ready(req_ready1), .MEMread(MEMread1), .MEMwrite(MEMwrite1),
        .address(address1), .data(data1), .MEM_result(MEM_result1),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1), .freeze(freeze1)
    );

    mem_access_ctrl #(.BASE_ADDR(1024), .MEM_WORDS(65536), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_read(req_read3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .req_ready(req_ready3), .MEMread(MEMread3), .MEMwrite(MEMwrite3),
        .address(address3), .data(data3), .MEM_result(MEM_result3),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3), .freeze(freeze3)
    );

    // Memory model: word at 1032 holds 77, every other word reads 0x12345678.
    assign MEM_result1 = (address1 == 32'd1032) ? 32'd77 : 32'h1234_5678;
    assign MEM_result3 = (address3 == 32'd1032) ? 32'd77 : 32'h1234_5678;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'd1020;
        bad_addr[1] = 32'd1026;
        bad_addr[2] = 32'd263168;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_valid1 = 1'b0; req_read1 = 1'b0; req_addr1 = 32'd0; req_wdata1 = 32'd0;
        req_valid3 = 1'b0; req_read3 = 1'b0; req_addr3 = 32'd0; req_wdata3 = 32'd0;

        // Reset values before any clock edge.
        #2;
        chk("rst_ready1", {31'd0, req_ready1}, 32'd1);
        chk("rst_freeze1", {31'd0, freeze1}, 32'd0);
        chk("rst_strobes3", {30'd0, MEMread3, MEMwrite3}, 32'd0);
        chk("rst_resp3", {30'd0, resp_valid3, resp_err3}, 32'd0);
        chk("rst_addr3", address3, 32'd0);
        chk("rst_data3", data3, 32'd0);
        chk("rst_rdata3", resp_rdata3, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Store, WAIT_CYCLES=1: addr 1032, data -5.
        req_valid1 = 1'b1; req_read1 = 1'b0; req_addr1 = 32'd1032; req_wdata1 = -32'sd5;
        tick();                                   // acceptance edge E
        req_valid1 = 1'b0;
        chk("st1_write", {31'd0, MEMwrite1}, 32'd1);
        chk("st1_read", {31'd0, MEMread1}, 32'd0);
        chk("st1_addr", address1, 32'd1032);
        chk("st1_data", data1, -32'sd5);
        chk("st1_freeze", {31'd0, freeze1}, 32'd1);
        chk("st1_ready", {31'd0, req_ready1}, 32'd0);
        chk("st1_novalid", {31'd0, resp_valid1}, 32'd0);
        tick();                                   // E+2 cycle
        chk("st1_valid", {31'd0, resp_valid1}, 32'd1);
        chk("st1_err", {31'd0, resp_err1}, 32'd0);
        chk("st1_write_done", {31'd0, MEMwrite1}, 32'd0);
        chk("st1_freeze_done", {31'd0, freeze1}, 32'd1);
        chk("st1_addr_hold", address1, 32'd1032);
        tick();
        chk("st1_idle_valid", {31'd0, resp_valid1}, 32'd0);
        chk("st1_idle_ready", {31'd0, req_ready1}, 32'd1);
        chk("st1_idle_freeze", {31'd0, freeze1}, 32'd0);

        // Load, WAIT_CYCLES=3: addr 1032 returns 77.
        req_valid3 = 1'b1; req_read3 = 1'b1; req_addr3 = 32'd1032; req_wdata3 = 32'd0;
        tick();
        req_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ld3_read_c%0d", i), {31'd0, MEMread3}, 32'd1);
            chk($sformatf("ld3_write_c%0d", i), {31'd0, MEMwrite3}, 32'd0);
            chk($sformatf("ld3_valid_c%0d", i), {31'd0, resp_valid3}, 32'd0);
            chk($sformatf("ld3_addr_c%0d", i), address3, 32'd1032);
            tick();
        end
        chk("ld3_valid", {31'd0, resp_valid3}, 32'd1);
        chk("ld3_err", {31'd0, resp_err3}, 32'd0);
        chk("ld3_rdata", resp_rdata3, 32'd77);
        chk("ld3_read_done", {31'd0, MEMread3}, 32'd0);
        tick();
        chk("ld3_idle_valid", {31'd0, resp_valid3}, 32'd0);
        chk("ld3_idle_ready", {31'd0, req_ready3}, 32'd1);

        // Invalid addresses: below base, misaligned, one past the end.
        for (int k = 0; k < 3; k++) begin
            req_valid3 = 1'b1; req_read3 = 1'b1; req_addr3 = bad_addr[k];
            tick();
            req_valid3 = 1'b0;
            chk($sformatf("bad%0d_valid", k), {31'd0, resp_valid3}, 32'd1);
            chk($sformatf("bad%0d_err", k), {31'd0, resp_err3}, 32'd1);
            chk($sformatf("bad%0d_strobes", k), {30'd0, MEMread3, MEMwrite3}, 32'd0);
            chk($sformatf("bad%0d_rdata", k), resp_rdata3, 32'd77);
            chk($sformatf("bad%0d_freeze", k), {31'd0, freeze3}, 32'd1);
            tick();
            chk($sformatf("bad%0d_idle", k), {30'd0, resp_valid3, resp_err3}, 32'd0);
        end

        // Back-to-back with req_valid held: store 99 at 1100, then load from 1100.
        req_valid3 = 1'b1; req_read3 = 1'b0; req_addr3 = 32'd1100; req_wdata3 = 32'd99;
        tick();                                   // store accepted
        req_read3 = 1'b1; req_wdata3 = 32'd0;     // next request already pending
        chk("b2b_st_write", {31'd0, MEMwrite3}, 32'd1);
        chk("b2b_st_data", data3, 32'd99);
        tick();
        chk("b2b_st_write_once", {31'd0, MEMwrite3}, 32'd0);
        chk("b2b_st_freeze", {31'd0, freeze3}, 32'd1);
        tick();
        chk("b2b_st_write_c3", {31'd0, MEMwrite3}, 32'd0);
        tick();
        chk("b2b_st_done", {31'd0, resp_valid3}, 32'd1);
        chk("b2b_st_done_rdata", resp_rdata3, 32'd77);
        chk("b2b_st_done_freeze", {31'd0, freeze3}, 32'd1);
        tick();
        chk("b2b_idle_ready", {31'd0, req_ready3}, 32'd1);
        chk("b2b_idle_freeze", {31'd0, freeze3}, 32'd0);
        chk("b2b_idle_read", {31'd0, MEMread3}, 32'd0);
        tick();                                   // load accepted on first IDLE edge
        req_valid3 = 1'b0;
        chk("b2b_ld_read", {31'd0, MEMread3}, 32'd1);
        chk("b2b_ld_addr", address3, 32'd1100);
        chk("b2b_ld_freeze", {31'd0, freeze3}, 32'd1);
        tick();
        tick();
        tick();
        chk("b2b_ld_valid", {31'd0, resp_valid3}, 32'd1);
        chk("b2b_ld_rdata", resp_rdata3, 32'h1234_5678);
        tick();

        // Reset in the middle of a load.
        req_valid3 = 1'b1; req_read3 = 1'b1; req_addr3 = 32'd1032;
        tick();
        req_valid3 = 1'b0;
        chk("mid_read_before", {31'd0, MEMread3}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_read_async", {31'd0, MEMread3}, 32'd0);
        chk("mid_freeze", {31'd0, freeze3}, 32'd0);
        chk("mid_ready", {31'd0, req_ready3}, 32'd1);
        chk("mid_addr", address3, 32'd0);
        chk("mid_rdata", resp_rdata3, 32'd0);
        chk("mid_resp", {30'd0, resp_valid3, resp_err3}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst_valid_c%0d", i), {31'd0, resp_valid3}, 32'd0);
            chk($sformatf("post_rst_read_c%0d", i), {31'd0, MEMread3}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
